inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch front end for the single-cycle RISC-V core. It owns the PC, fetches 32-bit instruction words from instruction memory over a request/grant/response handshake, and presents them to the decode/control stage. The control unit consumes `inst` and answers with `PCSel`/`alu_target` to redirect the fetch stream, so this block is the producer end of the control unit's `inst` input and the consumer of its `PCSel` output. A 2-entry instruction queue plus one outstanding memory request hides memory latency; redirects kill speculative sequential fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, word-aligned.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: response instruction word.
- `inst_valid` out 1: `inst`/`pc` hold a valid instruction.
- `inst` out 32: instruction to decode; queue head.
- `pc` out 32: address of `inst`.
- `inst_ready` in 1: core consumes head this cycle.
- `PCSel` in 1: 1 = redirect to `alu_target` (branch taken / jal / jalr), sampled only on consume.
- `alu_target` in 32: redirect address.
- `err_misalign` out 1: misaligned redirect pulse (see Configuration).

## Operation
- State: `fetch_pc` (next address to request), 2-entry queue {inst, pc}, `count` (0..2), FSM {IDLE, WAIT, WAIT_KILL}.
- IDLE: assert `imem_req` with `imem_addr=fetch_pc` when `count + outstanding < 2` (`outstanding` is 0 in IDLE). Stay IDLE until `imem_gnt`.
- On `imem_req & imem_gnt`: `fetch_pc <= fetch_pc + 4` (mod 2^32; 32'hFFFF_FFFC wraps to 0); tag request with its address; go WAIT.
- WAIT: on `imem_rvalid`, push {`imem_rdata`, tag} into queue, go IDLE. No new request while WAIT (one outstanding max).
- WAIT_KILL: on `imem_rvalid`, discard data, go IDLE.
- Consume: edge where `inst_valid & inst_ready`: pop head.
- Redirect: consume with `PCSel=1`: flush entire queue (`count <= 0`); `fetch_pc <= {alu_target[31:2],2'b00}`; WAIT -> WAIT_KILL; an ungranted pending request is dropped and next cycle `imem_addr` shows the new target (`imem_req` may stay high).
- `PCSel` ignored when no consume occurs.
- Simultaneous `imem_rvalid` + redirect: response discarded (queue flushed, not pushed).
- Simultaneous push + pop with `count=2` cannot occur (capacity rule); push + pop at `count=1` leaves `count=1`.
- `inst` shows 32'h0000_0013 (NOP) when `inst_valid=0`.
- Memory response ordering is in-order; `imem_rvalid` without outstanding request is ignored.

## Timing
- Reset (edge with `rst_n=0`): `imem_req=0`, `imem_addr=RESET_PC`, `fetch_pc=RESET_PC`, `inst_valid=0`, `inst=32'h0000_0013`, `pc=RESET_PC`, `err_misalign=0`, `count=0`, FSM=IDLE, kill state cleared. Reset mid-transaction abandons the outstanding request; its late response is ignored.
- First `imem_req` in the first cycle after `rst_n` returns high.
- `imem_req`, `imem_addr` registered; held stable until `imem_gnt` except on redirect.
- Response earliest one cycle after grant; `inst_valid` rises the cycle after `imem_rvalid` (1-cycle push latency).
- With zero-wait memory (gnt immediate, rvalid next cycle) and `inst_ready=1`: one instruction every 2 cycles sustained; queue covers stalls.
- Redirect penalty with ready memory: target instruction valid 3 cycles after redirect edge (4 if a killed response is pending).

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined: on redirect with `alu_target[1:0]!=0`, `err_misalign` is 1 for exactly the next cycle; fetch still proceeds from the target with low bits cleared.
- Not defined: check logic absent, `err_misalign` tied 0; low bits still cleared.

## Test plan
- Reset/startup: `rst_n=0` 3 cycles, `RESET_PC=0`, immediate memory -> all outputs at reset values; first `imem_addr=0`, then 4, 8; `inst_valid` with `pc=0`, `inst=32'h00208233`.
- Backpressure: `inst_ready=0` for 10 cycles -> exactly 2 grants (addr 0, 4), `imem_req` low afterward, no queue overflow; release yields pc 0,4,8 in order.
- Taken branch: consume `beq` at pc=8 with `PCSel=1`, `alu_target=32'h14` while fetch of 0xC in flight -> 0xC response discarded, next `imem_addr=32'h14`, next `pc=32'h14`.
- Redirect coincident with `imem_rvalid`, and redirect with ungranted request (gnt held low) -> no stale instruction ever presented; `imem_addr` switches to target.
- Random latency (gnt 0-3, rvalid 1-4 cycles) with random `inst_ready` -> `pc` sequence matches reference model; wrap from 32'hFFFF_FFFC to 0.
- With `IFU_MISALIGN_CHECK_EN`: redirect to 32'h102 -> `err_misalign` 1-cycle pulse, fetch at 32'h100; without macro `err_misalign` stays 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over req/gnt/rvalid, buffers 2 instructions.
// Optional misaligned-redirect pulse enabled by defining IFU_MISALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        inst_ready,
  input  logic        PCSel,
  input  logic [31:0] alu_target,
  output logic        err_misalign
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;
  localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_MASK  = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;
  localparam logic [CW-1:0]   DEPTH      = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_KILL} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] tag, tag_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [XLEN-1:0] q0_inst, q0_inst_nxt, q0_pc, q0_pc_nxt;
  logic [XLEN-1:0] q1_inst, q1_inst_nxt, q1_pc, q1_pc_nxt;
  logic            req_nxt, valid_nxt;
  logic            pop, push, redirect;

  // The queue head registers drive the decode-facing outputs directly.
  assign imem_addr = fetch_pc;
  assign inst      = q0_inst;
  assign pc        = q0_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      tag        <= RESET_PC;
      count      <= '0;
      q0_inst    <= NOP;
      q0_pc      <= RESET_PC;
      q1_inst    <= NOP;
      q1_pc      <= RESET_PC;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      tag        <= tag_nxt;
      count      <= count_nxt;
      q0_inst    <= q0_inst_nxt;
      q0_pc      <= q0_pc_nxt;
      q1_inst    <= q1_inst_nxt;
      q1_pc      <= q1_pc_nxt;
      imem_req   <= req_nxt;
      inst_valid <= valid_nxt;
    end
  end

  // Next-state: fetch FSM, redirect/kill handling and queue push/pop.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    tag_nxt      = tag;
    count_nxt    = count;
    q0_inst_nxt  = q0_inst;
    q0_pc_nxt    = q0_pc;
    q1_inst_nxt  = q1_inst;
    q1_pc_nxt    = q1_pc;
    push         = 1'b0;
    pop          = inst_valid & inst_ready;
    redirect     = pop & PCSel;

    case (state)
      IDLE: begin
        if (imem_req && imem_gnt) begin
          // A grant that coincides with a redirect is already stale.
          state_nxt    = redirect ? WAIT_KILL : WAIT;
          tag_nxt      = fetch_pc;
          fetch_pc_nxt = fetch_pc + INST_BYTES;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = IDLE;
          push      = ~redirect;
        end else if (redirect) begin
          state_nxt = WAIT_KILL;
        end
      end
      WAIT_KILL: begin
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect) begin
      fetch_pc_nxt = alu_target & WORD_MASK;
      count_nxt    = '0;
    end else if (push && pop) begin
      q0_inst_nxt = imem_rdata;
      q0_pc_nxt   = tag;
    end else if (pop) begin
      q0_inst_nxt = q1_inst;
      q0_pc_nxt   = q1_pc;
      count_nxt   = count - CW'(1);
    end else if (push) begin
      if (count == '0) begin
        q0_inst_nxt = imem_rdata;
        q0_pc_nxt   = tag;
      end else begin
        q1_inst_nxt = imem_rdata;
        q1_pc_nxt   = tag;
      end
      count_nxt = count + CW'(1);
    end

    if (count_nxt == '0) q0_inst_nxt = NOP;
    valid_nxt = (count_nxt != '0);
    req_nxt   = (state_nxt == IDLE) && (count_nxt < DEPTH);
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic err_nxt;

  always_comb begin
    err_nxt = redirect & (alu_target[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_misalign <= 1'b0;
    else        err_misalign <= err_nxt;
  end
`else
  assign err_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed vector table plus a randomized-latency memory/consumer run for inst_fetch_unit.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W0   = 32'h0020_8233;
  localparam logic [31:0] W4   = 32'h0041_0113;
  localparam logic [31:0] W8   = 32'h0020_8463;
  localparam logic [31:0] WC   = 32'h00c0_0093;
  localparam logic [31:0] W14  = 32'h0140_0513;
  localparam logic [31:0] W100 = 32'h0400_0593;
  localparam logic [31:0] W104 = 32'hBADB_AD00;
  localparam logic [31:0] W80  = 32'h00a0_0613;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_ready;
  logic        PCSel;
  logic [31:0] alu_target;
  logic        err_misalign;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .inst_ready(inst_ready),
    .PCSel(PCSel), .alu_target(alu_target), .err_misalign(err_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        sel;
    logic [31:0] tgt;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        val;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic rdy, input logic sel, input logic [31:0] tgt, input logic chk,
                     input logic req, input logic [31:0] addr, input logic val,
                     input logic [31:0] epc, input logic [31:0] einst, input logic err);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.sel = sel; v.tgt = tgt;
    v.chk = chk; v.req = req; v.addr = addr; v.val = val; v.pc = epc; v.inst = einst; v.err = err;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h1234_5600;
  endfunction

  int          rsp_wait, gnt_wait, n_cons;
  logic        rsp_pend, started, exp_err, wrap_armed, saw_wrap, cons;
  logic [31:0] rsp_addr, exp_pc;

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; PCSel = 1'b0; alu_target = '0;

    //  rst gnt rv rdata  rdy sel tgt           chk req addr          val pc            inst  err
    add(0, 1, 0, 0,     0, 0, 0,            0, 0, 32'h0,        0, 32'h0,        NOP,  0);
    add(0, 1, 0, 0,     0, 0, 0,            1, 0, 32'h0,        0, 32'h0,        NOP,  0);
    add(0, 1, 0, 0,     0, 0, 0,            1, 0, 32'h0,        0, 32'h0,        NOP,  0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 0, 32'h0,        0, 32'h0,        NOP,  0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'h0,        0, 32'h0,        NOP,  0);
    add(1, 0, 1, W0,    0, 0, 0,            1, 0, 32'h4,        0, 32'h0,        NOP,  0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'h4,        1, 32'h0,        W0,   0);
    add(1, 0, 1, W4,    0, 0, 0,            1, 0, 32'h8,        1, 32'h0,        W0,   0);
    // Queue full: stray rvalid and PCSel without consume must be ignored.
    for (int i = 0; i < 4; i++)
      add(1, 1, 1, JUNK, 0, 1, 32'h99,      1, 0, 32'h8,        1, 32'h0,        W0,   0);
    add(1, 0, 0, 0,     1, 0, 0,            1, 0, 32'h8,        1, 32'h0,        W0,   0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'h8,        1, 32'h4,        W4,   0);
    add(1, 0, 1, W8,    1, 0, 0,            1, 0, 32'hC,        1, 32'h4,        W4,   0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'hC,        1, 32'h8,        W8,   0);
    // Taken branch at pc 8 while 0xC is in flight.
    add(1, 0, 0, 0,     1, 1, 32'h14,       1, 0, 32'h10,       1, 32'h8,        W8,   0);
    add(1, 0, 1, WC,    0, 0, 0,            1, 0, 32'h14,       0, 32'h0,        NOP,  0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'h14,       0, 32'h0,        NOP,  0);
    add(1, 0, 1, W14,   0, 0, 0,            1, 0, 32'h18,       0, 32'h0,        NOP,  0);
    add(1, 0, 0, 0,     0, 0, 0,            1, 1, 32'h18,       1, 32'h14,       W14,  0);
    // Redirect with an ungranted request, misaligned target.
    add(1, 0, 0, 0,     1, 1, 32'h102,      1, 1, 32'h18,       1, 32'h14,       W14,  0);
    add(1, 0, 1, JUNK,  0, 0, 0,            1, 1, 32'h100,      0, 32'h0,        NOP,  MIS);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'h100,      0, 32'h0,        NOP,  0);
    add(1, 0, 1, W100,  0, 0, 0,            1, 0, 32'h104,      0, 32'h0,        NOP,  0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'h104,      1, 32'h100,      W100, 0);
    // Redirect coincident with the response.
    add(1, 0, 1, W104,  1, 1, 32'h80,       1, 0, 32'h108,      1, 32'h100,      W100, 0);
    add(1, 1, 0, 0,     0, 0, 0,            1, 1, 32'h80,       0, 32'h0,        NOP,  0);
    add(1, 0, 1, W80,   0, 0, 0,            1, 0, 32'h84,       0, 32'h0,        NOP,  0);
    add(1, 0, 0, 0,     0, 0, 0,            1, 1, 32'h84,       1, 32'h80,       W80,  0);

    foreach (tv[i]) begin
      rst_n = tv[i].rst; imem_gnt = tv[i].gnt; imem_rvalid = tv[i].rv; imem_rdata = tv[i].rdata;
      inst_ready = tv[i].rdy; PCSel = tv[i].sel; alu_target = tv[i].tgt;
      @(negedge clk);
      if (tv[i].chk) begin
        check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tv[i].req));
        check($sformatf("row%0d imem_addr", i), imem_addr, tv[i].addr);
        check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tv[i].val));
        check($sformatf("row%0d inst", i), inst, tv[i].inst);
        check($sformatf("row%0d err_misalign", i), 32'(err_misalign), 32'(tv[i].err));
        if (tv[i].val) check($sformatf("row%0d pc", i), pc, tv[i].pc);
      end
      @(posedge clk); #1;
    end

    // Random gnt/rvalid latency with random consumer and redirects near the top of memory.
    rsp_pend = 1'b0; rsp_wait = 0; gnt_wait = 0; rsp_addr = '0; n_cons = 0;
    started = 1'b0; exp_err = 1'b0; wrap_armed = 1'b0; saw_wrap = 1'b0; exp_pc = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      if (rsp_pend) begin
        if (rsp_wait == 0) begin
          imem_rvalid = 1'b1; imem_rdata = word(rsp_addr); rsp_pend = 1'b0;
        end else rsp_wait--;
      end
      if (imem_req) begin
        if (gnt_wait == 0) begin
          imem_gnt = 1'b1; rsp_pend = 1'b1; rsp_addr = imem_addr;
          rsp_wait = int'($urandom_range(0, 3)); gnt_wait = int'($urandom_range(0, 3));
        end else gnt_wait--;
      end
      inst_ready = 1'b0; PCSel = 1'b0; alu_target = '0;
      if (inst_valid) begin
        inst_ready = started ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (inst_ready && (!started || $urandom_range(0, 9) == 0)) begin
          PCSel = 1'b1;
          case ($urandom_range(0, 3))
            0:       alu_target = 32'hFFFF_FFF0;
            1:       alu_target = 32'hFFFF_FFF6;
            2:       alu_target = 32'hFFFF_FFE8;
            default: alu_target = 32'h0000_0200;
          endcase
        end
      end
      @(negedge clk);
      check($sformatf("rnd%0d err_misalign", cyc), 32'(err_misalign), 32'(exp_err));
      cons = inst_valid & inst_ready;
      if (cons) begin
        if (started) begin
          check($sformatf("rnd%0d pc", cyc), pc, exp_pc);
          check($sformatf("rnd%0d inst", cyc), inst, word(exp_pc));
          if (wrap_armed && exp_pc == 32'h0 && pc == 32'h0) saw_wrap = 1'b1;
          n_cons++;
        end
        if (PCSel) begin
          exp_pc = alu_target & 32'hFFFF_FFFC;
          wrap_armed = 1'b0;
        end else begin
          wrap_armed = (exp_pc == 32'hFFFF_FFFC);
          exp_pc = exp_pc + 32'd4;
        end
        started = 1'b1;
      end
      exp_err = MIS & cons & PCSel & (alu_target[1:0] != 2'b00);
      @(posedge clk); #1;
    end
    check("enough_consumes", 32'(n_cons > 50), 32'd1);
    check("pc_wrap_seen", 32'(saw_wrap), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
